amp_seq_ctrl: RTL
=================

Name: amp_seq_ctrl

Overview:
Parametrised power-up/fault sequencer for one or more class-D amplifier devices sharing a clock domain.
- Power-up order: staggered enable, settle wait, config-send handshake, settle, then unmute gated by a debounced audio lock.
- Adds fault monitoring, timed retry with backoff, and a lockout state.
- Sits between the I2S/audio front end (lock indication), the amp config sender (handshake) and the amp control pins.

Parameters:
NUM_AMPS, 2, number of amp devices (width of nenable_out, nerror_in); 1..8
TIMER_W, 16, width of the shared wait timer
STAGGER_CYC, 4, cycles between successive amp enables (≥1)
ENABLE_WAIT_CYC, 8, cycles after last amp enabled before config is sent (≥1)
CFG_TIMEOUT_CYC, 16, max cycles to wait for cfg_done_in (≥1)
SETTLE_CYC, 4, cycles after cfg_done_in before entering RUN (≥1)
LOCK_STABLE_CYC, 3, consecutive cycles audio_locked_in must be high before unmute (≥1)
BACKOFF_CYC, 10, cycles of disabled wait after a fault before retry (≥1)
MAX_RETRY, 2, faults tolerated before LOCKOUT (≥1)

Ports:
clk_in  in  1  system clock
resetb  in  1  asynchronous active-low reset
audio_locked_in  in  1  audio path locked (synchronous to clk_in)
nerror_in  in  NUM_AMPS  per-amp fault, active-low, asynchronous to clk_in
cfg_done_in  in  1  one-cycle pulse from config sender: config complete
nenable_out  out  NUM_AMPS  per-amp enable, active-low
nmute_out  out  1  amp mute, active-low (1 = playing)
send_config_out  out  1  level request to config sender
fault_out  out  1  high in LOCKOUT
state_out  out  4  current state encoding (debug)
retry_cnt_out  out  $clog2(MAX_RETRY+1)  faults seen since reset

Behaviour:
- Reset (async assert, sync release): state INIT; nenable_out all 1; nmute_out 0; send_config_out 0; fault_out 0; retry_cnt 0; lock counter 0; sync flops 1.
- All outputs are registered. No combinational path from input to output.
- nerror_in passes through a 2-flop synchroniser per bit. err = any synchronised bit low.
- Timer: loaded with N-1 on state entry and counts down; "expired" means count == 0. A timed state therefore lasts exactly N cycles.
- States and transitions:
  - INIT: lasts 1 cycle, then ENABLE.
  - ENABLE: amp i's nenable clears on cycle i*STAGGER_CYC after entry. Leaves (NUM_AMPS-1)*STAGGER_CYC+1 cycles after entry, to ENABLE_WAIT. err is ignored here.
  - ENABLE_WAIT: lasts ENABLE_WAIT_CYC, then SEND_CFG. err is ignored.
  - SEND_CFG: send_config_out=1. On cfg_done_in, go to SETTLE. If the timer expires without cfg_done_in, go to FAULT. err also goes to FAULT.
  - SETTLE: send_config_out stays 1. Lasts SETTLE_CYC, then RUN. err goes to FAULT.
  - RUN: send_config_out=1. nmute_out=1 only when the lock counter has reached LOCK_STABLE_CYC. audio_locked_in low clears the counter; nmute_out drops on the next edge. err goes to FAULT.
  - FAULT: lasts 1 cycle. nmute_out=0, nenable_out all 1, send_config_out=0 (all at the entry edge). retry_cnt increments, saturating. Goes to LOCKOUT if the new retry_cnt == MAX_RETRY, else BACKOFF.
  - BACKOFF: all outputs in the disabled state. Lasts BACKOFF_CYC, then INIT.
  - LOCKOUT: terminal; fault_out=1, outputs disabled. Exits only by reset.
- Lock counter: counts only in RUN and saturates at LOCK_STABLE_CYC. It is 0 in every other state.
- Simultaneous events:
  - err wins over cfg_done_in and over timer expiry.
  - cfg_done_in in the same cycle as SEND_CFG timer expiry counts as success.
  - cfg_done_in outside SEND_CFG is ignored.
- retry_cnt is cleared only by reset.
- Reset mid-sequence returns immediately to the reset values, with no partial outputs.

Decomposition:
- Package amp_seq_pkg: state encodings (INIT 0, ENABLE 1, ENABLE_WAIT 2, SEND_CFG 3, SETTLE 4, RUN 5, FAULT 6, BACKOFF 7, LOCKOUT 8) and a 4-bit state width constant.
- One sub-module, amp_seq_timer: loadable TIMER_W down-counter with load, value and expired outputs. The same sub-module serves the stagger, wait, timeout and backoff timing.
- Synchroniser and lock counter are inline in amp_seq_ctrl.

Test Plan:
1. Defaults, nerror all 1, lock high, cfg_done pulsed on the 3rd SEND_CFG cycle.
   -> nenable_out[0] clears 1 cycle after INIT; nenable_out[1] 4 cycles later.
   -> send_config_out rises 8 cycles after nenable_out[1].
   -> RUN 4 cycles after cfg_done; nmute_out rises 3 cycles after RUN entry.
2. In RUN, drop audio_locked_in for 1 cycle.
   -> nmute_out 0 the next cycle.
   -> nmute_out returns 3 cycles after lock is high again; nenable_out unchanged.
3. Never pulse cfg_done_in.
   -> FAULT after exactly 16 SEND_CFG cycles; retry_cnt_out=1; BACKOFF 10 cycles; INIT again.
4. Pull nerror_in[1] low in RUN.
   -> nmute_out=0 and nenable_out=2'b11 3 cycles later (2 sync + 1).
   -> The second fault gives LOCKOUT, fault_out=1, held indefinitely until resetb pulse.
5. nerror_in low during ENABLE_WAIT only, released before SEND_CFG -> no FAULT; normal sequence.
6. Assert resetb low mid-SETTLE and mid-BACKOFF -> all outputs at reset values asynchronously; full sequence restarts after release; retry_cnt_out=0.

Source files
------------

// File: rtl/amp_seq_pkg.sv
// -----------------------------------------------------------------------------
// amp_seq_pkg
//   Shared constants for the class-D amplifier power-up/fault sequencer.
//   The state codes are visible on amp_seq_ctrl.state_out, so they are fixed
//   numeric values rather than an enum. Firmware and debug tools depend on them.
// -----------------------------------------------------------------------------
package amp_seq_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_INIT        = 4'd0;
    localparam logic [STATE_W-1:0] ST_ENABLE      = 4'd1;
    localparam logic [STATE_W-1:0] ST_ENABLE_WAIT = 4'd2;
    localparam logic [STATE_W-1:0] ST_SEND_CFG    = 4'd3;
    localparam logic [STATE_W-1:0] ST_SETTLE      = 4'd4;
    localparam logic [STATE_W-1:0] ST_RUN         = 4'd5;
    localparam logic [STATE_W-1:0] ST_FAULT       = 4'd6;
    localparam logic [STATE_W-1:0] ST_BACKOFF     = 4'd7;
    localparam logic [STATE_W-1:0] ST_LOCKOUT     = 4'd8;

    // States in which every amp must be held disabled.
    function automatic logic is_disabled_state(input logic [STATE_W-1:0] st);
        return (st == ST_INIT) || (st == ST_FAULT) ||
               (st == ST_BACKOFF) || (st == ST_LOCKOUT);
    endfunction

endpackage

// File: rtl/amp_seq_timer.sv
// -----------------------------------------------------------------------------
// amp_seq_timer
//   Loadable down-counter shared by all timed states of amp_seq_ctrl. Load it
//   with N-1 on state entry. expired_o then goes high in the N-th cycle of the
//   state. The counter holds at zero once it gets there.
//
//   Ports
//     clk_in      system clock
//     resetb      asynchronous active-low reset
//     load_i      load load_val_i on this edge; load takes priority over counting
//     load_val_i  value to load
//     value_o     current count
//     expired_o   count == 0
// -----------------------------------------------------------------------------
module amp_seq_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk_in,
    input  logic               resetb,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic [TIMER_W-1:0] value_o,
    output logic               expired_o
);

    logic [TIMER_W-1:0] value_q;
    logic [TIMER_W-1:0] value_d;

    always_comb begin
        // NOTE: assign a default first so every path drives value_d;
        // otherwise the tool infers a latch.
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (value_q != '0) begin
            value_d = value_q - TIMER_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments. All flops then
    // sample pre-edge values and simulation matches the synthesised netlist.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o   = value_q;
    assign expired_o = (value_q == '0);

endmodule

// File: rtl/amp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// amp_seq_ctrl
//   Power-up and fault sequencer for NUM_AMPS class-D amplifiers.
//
//   Power-up order:
//     1. Enable the amps one after another, STAGGER_CYC cycles apart.
//     2. Wait ENABLE_WAIT_CYC cycles.
//     3. Request config and wait up to CFG_TIMEOUT_CYC cycles for cfg_done_in.
//     4. Settle for SETTLE_CYC cycles.
//     5. Run. Unmute once audio lock has been stable for LOCK_STABLE_CYC cycles.
//
//   Faults:
//     - A fault is either a synchronised amp error or a config timeout.
//     - A fault disables everything and waits BACKOFF_CYC cycles, then retries.
//     - The MAX_RETRY-th fault parks the block in LOCKOUT until reset.
//
//   Reset:
//     resetb is asserted asynchronously. Its release is expected to be
//     synchronised to clk_in upstream.
//
//   Outputs:
//     Every output comes straight from a flop. Output next-values are derived
//     from the next state, so they change on the same edge as the state.
//
//   Ports
//     clk_in           system clock
//     resetb           asynchronous active-low reset
//     audio_locked_in  audio path locked (clk_in domain)
//     nerror_in        per-amp fault, active-low, asynchronous
//     cfg_done_in      one-cycle "config complete" pulse
//     nenable_out      per-amp enable, active-low
//     nmute_out        mute, active-low (1 = playing)
//     send_config_out  config request level
//     fault_out        high in LOCKOUT
//     state_out        current state code (debug)
//     retry_cnt_out    faults seen since reset (saturating)
// -----------------------------------------------------------------------------
module amp_seq_ctrl
    import amp_seq_pkg::*;
#(
    parameter int NUM_AMPS        = 2,
    parameter int TIMER_W         = 16,
    parameter int STAGGER_CYC     = 4,
    parameter int ENABLE_WAIT_CYC = 8,
    parameter int CFG_TIMEOUT_CYC = 16,
    parameter int SETTLE_CYC      = 4,
    parameter int LOCK_STABLE_CYC = 3,
    parameter int BACKOFF_CYC     = 10,
    parameter int MAX_RETRY       = 2
) (
    input  logic                             clk_in,
    input  logic                             resetb,
    input  logic                             audio_locked_in,
    input  logic [NUM_AMPS-1:0]              nerror_in,
    input  logic                             cfg_done_in,
    output logic [NUM_AMPS-1:0]              nenable_out,
    output logic                             nmute_out,
    output logic                             send_config_out,
    output logic                             fault_out,
    output logic [STATE_W-1:0]               state_out,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt_out
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int LOCK_W  = $clog2(LOCK_STABLE_CYC + 1);

    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [LOCK_W-1:0]  LOCK_MAX  = LOCK_W'(LOCK_STABLE_CYC);

    // Timer load values (N-1). ENABLE must cover the whole stagger window:
    // it lasts (NUM_AMPS-1)*STAGGER_CYC + 1 cycles.
    localparam logic [TIMER_W-1:0] T_ENABLE  = TIMER_W'((NUM_AMPS - 1) * STAGGER_CYC);
    localparam logic [TIMER_W-1:0] T_EN_WAIT = TIMER_W'(ENABLE_WAIT_CYC - 1);
    localparam logic [TIMER_W-1:0] T_CFG     = TIMER_W'(CFG_TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] T_SETTLE  = TIMER_W'(SETTLE_CYC - 1);
    localparam logic [TIMER_W-1:0] T_BACKOFF = TIMER_W'(BACKOFF_CYC - 1);

    logic [STATE_W-1:0]  state_q,    state_d;
    logic [NUM_AMPS-1:0] nenable_q,  nenable_d;
    logic                nmute_q,    nmute_d;
    logic                send_cfg_q, send_cfg_d;
    logic                fault_q,    fault_d;
    logic [RETRY_W-1:0]  retry_q,    retry_d;
    logic [LOCK_W-1:0]   lock_q,     lock_d;

    logic [NUM_AMPS-1:0] nerr_meta_q;
    logic [NUM_AMPS-1:0] nerr_sync_q;
    logic                err;

    logic                tmr_load;
    logic [TIMER_W-1:0]  tmr_load_val;
    logic [TIMER_W-1:0]  tmr_value;
    logic                tmr_expired;

    // -------------------------------------------------------------------------
    // Error synchroniser. The flops reset to 1 (no fault), so a reset never
    // produces a spurious err in the first cycles after release.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            nerr_meta_q <= '1;
            nerr_sync_q <= '1;
        end else begin
            nerr_meta_q <= nerror_in;
            nerr_sync_q <= nerr_meta_q;
        end
    end

    assign err = ~&nerr_sync_q;

    // -------------------------------------------------------------------------
    // Shared timer: reloaded on every state change, using the entered state.
    // -------------------------------------------------------------------------
    assign tmr_load = (state_d != state_q);

    always_comb begin
        tmr_load_val = '0;
        case (state_d)
            ST_ENABLE:      tmr_load_val = T_ENABLE;
            ST_ENABLE_WAIT: tmr_load_val = T_EN_WAIT;
            ST_SEND_CFG:    tmr_load_val = T_CFG;
            ST_SETTLE:      tmr_load_val = T_SETTLE;
            ST_BACKOFF:     tmr_load_val = T_BACKOFF;
            default:        tmr_load_val = '0;
        endcase
    end

    amp_seq_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk_in     (clk_in),
        .resetb     (resetb),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .value_o    (tmr_value),
        .expired_o  (tmr_expired)
    );

    // -------------------------------------------------------------------------
    // Next-state logic. In SEND_CFG, err has top priority. After err,
    // cfg_done_in beats a timeout that expires in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:        state_d = ST_ENABLE;
            ST_ENABLE:      if (tmr_expired) state_d = ST_ENABLE_WAIT;
            ST_ENABLE_WAIT: if (tmr_expired) state_d = ST_SEND_CFG;
            ST_SEND_CFG: begin
                if (err)              state_d = ST_FAULT;
                else if (cfg_done_in) state_d = ST_SETTLE;
                else if (tmr_expired) state_d = ST_FAULT;
            end
            ST_SETTLE: begin
                if (err)              state_d = ST_FAULT;
                else if (tmr_expired) state_d = ST_RUN;
            end
            ST_RUN:         if (err) state_d = ST_FAULT;
            // retry_q was already incremented on the edge that entered FAULT.
            ST_FAULT:       state_d = (retry_q == RETRY_MAX) ? ST_LOCKOUT : ST_BACKOFF;
            ST_BACKOFF:     if (tmr_expired) state_d = ST_INIT;
            ST_LOCKOUT:     state_d = ST_LOCKOUT;
            default:        state_d = ST_INIT;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output next-values.
    // -------------------------------------------------------------------------
    always_comb begin
        nenable_d  = nenable_q;
        nmute_d    = 1'b0;
        send_cfg_d = 1'b0;
        fault_d    = 1'b0;
        retry_d    = retry_q;
        lock_d     = '0;

        // In ENABLE, cycle index k = T_ENABLE - timer. Amp i is released at
        // the end of cycle k = i*STAGGER_CYC. The last amp is released on the
        // same edge that leaves ENABLE.
        if (state_q == ST_ENABLE) begin
            for (int i = 0; i < NUM_AMPS; i++) begin
                if (tmr_value == TIMER_W'((NUM_AMPS - 1 - i) * STAGGER_CYC)) begin
                    nenable_d[i] = 1'b0;
                end
            end
        end

        if (is_disabled_state(state_d)) begin
            nenable_d = '1;
        end

        if ((state_d == ST_SEND_CFG) || (state_d == ST_SETTLE) || (state_d == ST_RUN)) begin
            send_cfg_d = 1'b1;
        end

        // The lock counter only runs while staying in RUN. It restarts from 0
        // on every RUN entry, and on any cycle with the lock low.
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            if (!audio_locked_in) begin
                lock_d = '0;
            end else if (lock_q != LOCK_MAX) begin
                lock_d = lock_q + LOCK_W'(1);
            end else begin
                lock_d = lock_q;
            end
        end
        nmute_d = (state_d == ST_RUN) && (lock_d == LOCK_MAX);

        fault_d = (state_d == ST_LOCKOUT);

        if ((state_d == ST_FAULT) && (state_q != ST_FAULT) && (retry_q != RETRY_MAX)) begin
            retry_d = retry_q + RETRY_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state_q    <= ST_INIT;
            nenable_q  <= '1;
            nmute_q    <= 1'b0;
            send_cfg_q <= 1'b0;
            fault_q    <= 1'b0;
            retry_q    <= '0;
            lock_q     <= '0;
        end else begin
            state_q    <= state_d;
            nenable_q  <= nenable_d;
            nmute_q    <= nmute_d;
            send_cfg_q <= send_cfg_d;
            fault_q    <= fault_d;
            retry_q    <= retry_d;
            lock_q     <= lock_d;
        end
    end

    assign nenable_out     = nenable_q;
    assign nmute_out       = nmute_q;
    assign send_config_out = send_cfg_q;
    assign fault_out       = fault_q;
    assign state_out       = state_q;
    assign retry_cnt_out   = retry_q;

endmodule
